// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the serial bus arbiter.
package bus_pkg;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 64;
    localparam int CRC_W      = 4;
    localparam int NUM_NODES  = 16;
    localparam int FRAME_BITS = ADDR_W + DATA_W + CRC_W;
    localparam int GAP_CYCLES = 1;
    localparam int ID_W       = 4;
    localparam int IDX_W      = 7;
    localparam int GAP_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner: first requester at or above ptr, wrapping.
module rr_pick #(
    parameter int N    = bus_pkg::NUM_NODES,
    parameter int ID_W = bus_pkg::ID_W
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);
    logic [ID_W-1:0] cand;

    // Scan N positions starting at ptr; keep the first hit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ID_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection and frame sequencing for a shared serial bus.
module bus_arbiter #(
    parameter int NUM_NODES  = bus_pkg::NUM_NODES,
    parameter int FRAME_BITS = bus_pkg::FRAME_BITS,
    parameter int GAP_CYCLES = bus_pkg::GAP_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_NODES-1:0]          req,
    output logic [NUM_NODES-1:0]          grant,
    output logic [bus_pkg::ID_W-1:0]      grant_id,
    output logic                          bus_busy,
    output logic [bus_pkg::IDX_W-1:0]     bit_idx,
    output logic                          frame_start,
    output logic                          frame_done,
    output logic                          abort
);
    import bus_pkg::*;

    state_t               state, state_n;
    logic [ID_W-1:0]      ptr, ptr_n;
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
    logic [NUM_NODES-1:0] grant_n;
    logic [ID_W-1:0]      grant_id_n;
    logic                 bus_busy_n, frame_start_n, frame_done_n, abort_n;
    logic [IDX_W-1:0]     bit_idx_n;
    logic                 pick_vld;
    logic [ID_W-1:0]      pick_idx;

    rr_pick #(.N(NUM_NODES), .ID_W(ID_W)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // State and every output are registered; the comb block below computes their next values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gap_cnt     <= '0;
            grant       <= '0;
            grant_id    <= '0;
            bus_busy    <= 1'b0;
            bit_idx     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            abort       <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            gap_cnt     <= gap_cnt_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            bus_busy    <= bus_busy_n;
            bit_idx     <= bit_idx_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
            abort       <= abort_n;
        end
    end

    // Next-state logic; end-of-frame is tested before the request drop so a
    // drop on the last bit still completes as a normal frame.
    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        gap_cnt_n     = gap_cnt;
        grant_n       = grant;
        grant_id_n    = grant_id;
        bus_busy_n    = bus_busy;
        bit_idx_n     = bit_idx;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        abort_n       = 1'b0;
        case (state)
            IDLE: begin
                grant_n    = '0;
                grant_id_n = '0;
                bus_busy_n = 1'b0;
                bit_idx_n  = '0;
                if (pick_vld) begin
                    state_n           = XFER;
                    grant_n[pick_idx] = 1'b1;
                    grant_id_n        = pick_idx;
                    bus_busy_n        = 1'b1;
                    frame_start_n     = 1'b1;
                    ptr_n = (pick_idx == ID_W'(NUM_NODES - 1)) ? '0 : pick_idx + ID_W'(1);
                end
            end
            XFER: begin
                if (bit_idx == IDX_W'(FRAME_BITS - 1) || !req[grant_id]) begin
                    state_n      = GAP;
                    grant_n      = '0;
                    grant_id_n   = '0;
                    bus_busy_n   = 1'b0;
                    bit_idx_n    = '0;
                    gap_cnt_n    = '0;
                    frame_done_n = (bit_idx == IDX_W'(FRAME_BITS - 1));
                    abort_n      = (bit_idx != IDX_W'(FRAME_BITS - 1));
                end else begin
                    bit_idx_n = bit_idx + IDX_W'(1);
                end
            end
            GAP: begin
                if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
                    state_n   = IDLE;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: outputs sampled and inputs driven on the falling edge.
module tb_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        bus_busy;
    logic [6:0]  bit_idx;
    logic        frame_start, frame_done, abort;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    bus_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .bit_idx     (bit_idx),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .abort       (abort)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Structural invariants checked every cycle once out of the first reset.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("pulse_excl", 32'($countones({frame_start, frame_done, abort}) <= 1), 32'd1);
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        end
    end

    initial begin
        int cnt;
        reset = 1'b1;
        req   = '0;
        step(2);
        chk("rst_grant", grant, 0);
        chk("rst_id", grant_id, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_idx", bit_idx, 0);
        chk("rst_pulses", {frame_start, frame_done, abort}, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        step(3);
        chk("idle_grant", grant, 0);
        chk("idle_busy", bus_busy, 0);

        // Single requester station 1: full frame then regrant.
        req = 16'h0002;
        step(1);
        chk("s1_grant", grant, 16'h0002);
        chk("s1_id", grant_id, 1);
        chk("s1_start", frame_start, 1);
        chk("s1_busy", bus_busy, 1);
        chk("s1_idx0", bit_idx, 0);
        for (int k = 1; k < 72; k++) begin
            step(1);
            chk("s1_hold", grant, 16'h0002);
            chk("s1_idx", bit_idx, k);
        end
        step(1);
        chk("s1_done", frame_done, 1);
        chk("s1_gap_grant", grant, 0);
        chk("s1_gap_busy", bus_busy, 0);
        chk("s1_gap_idx", bit_idx, 0);
        step(1);
        chk("s1_idle_grant", grant, 0);
        chk("s1_idle_done", frame_done, 0);
        step(1);
        chk("s1_regrant", grant, 16'h0002);
        chk("s1_restart", frame_start, 1);
        req = 16'h0000;
        step(1);
        chk("s1_abort0", abort, 1);
        chk("s1_abort0_grant", grant, 0);
        step(1);

        // Station 3 aborts at bit 10; ptr then sits at 4.
        req = 16'h0008;
        step(1);
        chk("s3_grant", grant, 16'h0008);
        step(10);
        chk("s3_idx10", bit_idx, 10);
        req = 16'h0000;
        step(1);
        chk("s3_abort", abort, 1);
        chk("s3_grant0", grant, 0);
        chk("s3_nodone", frame_done, 0);
        chk("s3_busy0", bus_busy, 0);
        step(1);
        chk("s3_idle_abort", abort, 0);

        // Stations 5 and 2 with ptr=4: 5 first, 2 ignored during the frame.
        req = 16'h0024;
        step(1);
        chk("rr_first", grant, 16'h0020);
        chk("rr_first_id", grant_id, 5);
        step(71);
        chk("rr_hold", grant, 16'h0020);
        chk("rr_idx71", bit_idx, 71);
        step(1);
        chk("rr_done", frame_done, 1);
        step(2);
        chk("rr_second", grant, 16'h0004);
        chk("rr_second_id", grant_id, 2);

        // Reset in the middle of a frame.
        step(40);
        chk("mid_idx40", bit_idx, 40);
        reset = 1'b1;
        step(1);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_id", grant_id, 0);
        chk("mid_rst_busy", bus_busy, 0);
        chk("mid_rst_idx", bit_idx, 0);
        chk("mid_rst_pulses", {frame_start, frame_done, abort}, 0);
        reset = 1'b0;
        req   = 16'h8001;
        step(1);
        chk("post_rst_grant", grant, 16'h0001);
        chk("post_rst_nopulse", {frame_done, abort}, 0);

        // Request drops on the last bit: completes normally.
        step(71);
        chk("last_idx71", bit_idx, 71);
        req = 16'h8000;
        step(1);
        chk("last_done", frame_done, 1);
        chk("last_noabort", abort, 0);
        step(2);
        chk("last_next_id", grant_id, 15);
        chk("last_next_grant", grant, 16'h8000);

        // All stations requesting: 0..15 then 0, each exactly 72 cycles.
        reset = 1'b1;
        req   = 16'h0000;
        step(1);
        reset = 1'b0;
        req   = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            step(1);
            chk("all_start", frame_start, 1);
            chk("all_id", grant_id, g % 16);
            chk("all_grant", grant, 32'd1 << (g % 16));
            cnt = 1;
            while (grant != 0 && cnt < 200) begin
                step(1);
                if (grant != 0) cnt++;
            end
            chk("all_len", cnt, 72);
            step(1);
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_NODES, default 16, number of stations sharing the single-bit serial bus.
REQ-002 Parameter FRAME_BITS, default 72, bits per frame: 4 address + 64 data + 4 CRC.
REQ-003 Parameter GAP_CYCLES, default 1, idle bus cycles between frames.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge clock shared with all stations.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req  in  NUM_NODES  per-station request; bit i high = station i holds a frame to send.
REQ-008 grant  out  NUM_NODES  one-hot bus ownership; all-zero when the bus is free.
REQ-009 grant_id  out  4  index of the granted station; 0 when grant is zero.
REQ-010 bus_busy  out  1  high while a frame is on the bus.
REQ-011 bit_idx  out  7  index of the frame bit currently driven, 0..FRAME_BITS-1.
REQ-012 frame_start  out  1  one-cycle pulse on the first bit of a frame.
REQ-013 frame_done  out  1  one-cycle pulse after a frame completes normally.
REQ-014 abort  out  1  one-cycle pulse when a frame is cut short.

Function
REQ-015 Three states: IDLE, XFER, GAP.
REQ-016 All outputs shall be registered.
REQ-017 IDLE, req nonzero: the next cycle shall enter XFER with grant one-hot, bit_idx=0, frame_start=1, bus_busy=1 (one-cycle request-to-grant latency).
REQ-018 IDLE, req zero: the block shall stay in IDLE with grant=0 and bus_busy=0.
REQ-019 Winner selection: round-robin, searching upward from pointer ptr with wrap from NUM_NODES-1 to 0.
REQ-020 ptr shall load (winner+1) mod NUM_NODES when a grant is issued.
REQ-021 ptr shall be 0 after reset, giving station 0 top priority first.
REQ-022 XFER: bit_idx shall increment by 1 per cycle, and grant shall hold stable.
REQ-023 XFER at bit_idx=FRAME_BITS-1: next cycle enters GAP, grant=0, bus_busy=0, bit_idx=0, frame_done=1; the grant lasts exactly FRAME_BITS cycles.
REQ-024 XFER, granted station's req low on a sampled edge: next cycle enters GAP, grant=0, abort=1, frame_done=0.
REQ-025 Requests from non-granted stations during XFER shall be ignored until arbitration in IDLE.
REQ-026 GAP: a counter shall hold the bus idle for GAP_CYCLES cycles, then return to IDLE.
REQ-027 Requests during GAP are not arbitrated; GAP-to-IDLE-to-grant gives minimum frame spacing GAP_CYCLES+1.
REQ-028 When FRAME_BITS ends on the same cycle as the granted req drops, frame_done shall win and abort shall stay 0.
REQ-029 frame_start, frame_done and abort shall be mutually exclusive in every cycle.
REQ-030 grant shall never have more than one bit set.

Reset
REQ-031 reset high at a clock edge: the next cycle shall enter IDLE from any state, including mid-XFER.
REQ-032 Reset values: grant=0, grant_id=0, bus_busy=0, bit_idx=0, all pulses 0, ptr=0, gap counter=0.
REQ-033 A frame interrupted by reset shall not produce frame_done or abort.

Structure
REQ-034 A shared package bus_pkg shall hold the state encoding, NUM_NODES, FRAME_BITS, GAP_CYCLES and field widths (address 4, data 64, CRC 4).
REQ-035 One sub-module, rr_pick, shall compute the combinational round-robin winner from req and ptr, outputting valid and a 4-bit index.

Verification
REQ-036 req=16'h0002 held: grant=16'h0002 one cycle later for 72 cycles; then frame_done; 1 gap cycle; 1 IDLE cycle; regrant to station 1.
REQ-037 req=16'hFFFF held: grant order 0,1,2,...,15,0, each grant exactly 72 cycles.
REQ-038 Station 3 granted; its req drops while bit_idx=10: abort=1 next cycle, grant=0, no frame_done; then GAP.
REQ-039 Stations 5 and 2 requesting with ptr=4: station 5 granted first, then station 2.
REQ-040 reset asserted at bit_idx=40: next cycle all outputs at reset values; with req=16'h8001 after release, station 0 granted first.
REQ-041 Granted req drops exactly on bit_idx=71: frame_done=1 and abort=0.
